lcd_bus_monitor: RTL
====================

Name: lcd_bus_monitor

Overview:
- Receiving end of the HD44780-style LCD bus that lcd_driver produces.
- Samples lcd_rs/lcd_rw/lcd_e/lcd_data and latches each transfer on the E falling edge.
- Decodes instructions and data writes into a 32-character shadow of the 16x2 display, plus cursor and display-control state.
- Used as an on-chip readback/self-check of what the clock modes actually wrote, and as the bus responder in system benches.

Parameters:
- MIN_E_HIGH, 2, minimum clk cycles E must be high for a transfer to be accepted.
- CLEAR_CHAR, 8'h20, fill character written by clear-display and by reset.
- LINE_LEN, 16, characters per line; two lines, 32 entries total.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- lcd_rs  input  1  register select: 0 = instruction, 1 = data.
- lcd_rw  input  1  0 = write, 1 = read.
- lcd_e  input  1  enable strobe.
- lcd_data  input  8  bus data.
- rd_index  input  5  shadow read address: 0-15 line 0, 16-31 line 1.
- rd_char  output  8  character at rd_index, registered.
- cursor_index  output  5  current write position.
- addr_valid  output  1  cursor is inside the visible window.
- display_on  output  1  display-control D bit.
- cursor_on  output  1  display-control C bit.
- blink_on  output  1  display-control B bit.
- busy  output  1  clear sequence in progress.
- wr_strobe  output  1  one-cycle pulse for each accepted data write.
- err_cnt  output  8  saturating count of rejected transfers.

Behaviour:
- Inputs are registered once.
- A high-time counter runs while the registered E is 1.
- A transfer fires on the cycle after the registered E goes 1->0, using the rs/rw/data sampled on the last E-high cycle.
- A transfer is rejected (err_cnt+1, saturating at 255, no other effect) if any of these holds:
  - E high time < MIN_E_HIGH;
  - rw=1 (reads are unsupported);
  - busy=1.
- FSM states:
  - IDLE: accepts transfers.
  - CLEAR: writes CLEAR_CHAR to entries 0..31, one per cycle; busy=1; returns to IDLE after entry 31, i.e. busy high for exactly 32 cycles.
- Reset values:
  - state=CLEAR, clear pointer=0, so busy=1 for 32 cycles after reset release.
  - cursor_index=0, addr_valid=1, I/D=1, display_on=0, cursor_on=0, blink_on=0.
  - wr_strobe=0, err_cnt=0, rd_char=0, cgram_mode=0.
- Instruction decode on the highest set bit (rs=0):
  - 0x01 clear: enter CLEAR; cursor=0; I/D=1; cgram_mode=0.
  - 0x02-0x03 home: cursor=0; addr_valid=1.
  - 0x04-0x07 entry mode: I/D=bit1. S bit is ignored.
  - 0x08-0x0F display control: D/C/B = bits 2/1/0.
  - 0x10-0x1F shift: if S/C=0, move cursor +1 when R/L=1, -1 when R/L=0, using the wrap rules below. If S/C=1, ignored.
  - 0x20-0x3F function set: accepted, no state change.
  - 0x40-0x7F CGRAM address: cgram_mode=1.
  - 0x80-0xFF DDRAM address: cgram_mode=0. Address 0x00-0x0F maps to index 0-15; 0x40-0x4F maps to index 16-31. Any other address sets addr_valid=0.
- Data write (rs=1):
  - Written to shadow[cursor] only if addr_valid=1 and cgram_mode=0; wr_strobe pulses in the same cycle.
  - Otherwise discarded silently; not counted as an error.
  - The cursor then advances per I/D, only when the write was stored.
- Wrap rules: index 15+1 -> 16; 31+1 -> 0; 0-1 -> 31; 16-1 -> 15.
- rd_char = shadow[rd_index], one-cycle latency, available in every state. Mid-clear reads return the partially cleared contents.
- Reset asserted mid-clear or mid-strobe: all state returns to reset values and the clear restarts from entry 0.

Decomposition:
- Package lcd_pkg holds:
  - opcode masks: CLR, HOME, ENTRY, DISP, SHIFT, FUNC, CGRAM, DDRAM;
  - line bases 8'h00 and 8'h40;
  - LINE_LEN;
  - CLEAR_CHAR;
  - FSM state encoding.
- Sub-module lcd_bus_sampler: input registers, E high-time counter, falling-edge detect. Outputs a one-cycle xfer pulse carrying rs, rw, data and a too_short flag.
- The shadow array is a 32x8 register file inside lcd_bus_monitor.

Test Plan:
- Release reset, wait -> busy high for exactly 32 cycles. Then every rd_index 0..31 returns 8'h20; display_on=0; err_cnt=0.
- Instr 0x80, data "12:34:56" (0x31,0x32,0x3A,...) -> indices 0-7 hold those bytes. cursor_index=8; wr_strobe pulses 8 times.
- Instr 0x8F, data 0x41, 0x42 -> index 15 = 0x41, index 16 = 0x42, cursor_index=17. Then instr 0x04, 0xC0, data 0x43 -> index 16 = 0x43, cursor_index=15.
- E high for 1 cycle with rs=1, data 0x55 -> no shadow change, err_cnt=1. Instr 0x01 followed by data 0x58 within 10 cycles -> data rejected, err_cnt=2, all entries 0x20 after 32 cycles.
- Instr 0x0E -> display_on=1, cursor_on=1, blink_on=0. Instr 0x90, then data 0x5A -> addr_valid=0, no write, no error. Instr 0x40, then data 0x1F -> cgram write discarded.
- Assert rst at clear entry 10 -> outputs return to reset values; busy stays high for a full 32 cycles after release.

Source files
------------

// File: rtl/lcd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lcd_pkg
// Description : Shared constants, opcode masks, FSM encoding and cursor helper
//               for the HD44780-style LCD bus monitor.
// Revision    : 1.0 - initial release
// ============================================================================
package lcd_pkg;

   // Instruction opcode masks; the highest set bit selects the instruction
   localparam logic [7:0] OP_CLR   = 8'h01;
   localparam logic [7:0] OP_HOME  = 8'h02;
   localparam logic [7:0] OP_ENTRY = 8'h04;
   localparam logic [7:0] OP_DISP  = 8'h08;
   localparam logic [7:0] OP_SHIFT = 8'h10;
   localparam logic [7:0] OP_FUNC  = 8'h20;
   localparam logic [7:0] OP_CGRAM = 8'h40;
   localparam logic [7:0] OP_DDRAM = 8'h80;

   // DDRAM base address of each display line
   localparam logic [7:0] LINE0_BASE = 8'h00;
   localparam logic [7:0] LINE1_BASE = 8'h40;

   // Display geometry and fill character
   localparam int         LCD_LINE_LEN   = 16;
   localparam int         NUM_ENTRIES    = 32;
   localparam logic [7:0] LCD_CLEAR_CHAR = 8'h20;

   // Monitor FSM encoding
   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } lcd_state_t;

   // Move the cursor one place; the 5-bit wrap gives 15->16, 31->0, 0->31, 16->15
   function automatic logic [4:0] step_cursor(input logic [4:0] cur, input logic inc);
      return inc ? (cur + 5'd1) : (cur - 5'd1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_bus_sampler.sv
`default_nettype none
// ============================================================================
// Module      : lcd_bus_sampler
// Description : Registers the LCD bus, measures E high time and emits a
//               one-cycle transfer pulse after the registered E falls.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_bus_sampler #(
   parameter int MIN_E_HIGH = 2
) (
   input  logic       clk,
   input  logic       rst,          // asynchronous, active-low
   input  logic       i_lcd_rs,
   input  logic       i_lcd_rw,
   input  logic       i_lcd_e,
   input  logic [7:0] i_lcd_data,
   output logic       o_xfer,
   output logic       o_rs,
   output logic       o_rw,
   output logic [7:0] o_data,
   output logic       o_too_short
);

   localparam logic [7:0] c_min_high = 8'(MIN_E_HIGH);

   logic       r_rs;
   logic       r_rw;
   logic       r_e;
   logic [7:0] r_data;
   logic       r_e_q;
   logic       r_cap_rs;
   logic       r_cap_rw;
   logic [7:0] r_cap_data;
   logic [7:0] r_high_cnt;

   // Single input register stage on the asynchronous bus
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rs   <= 1'b0;
         r_rw   <= 1'b0;
         r_e    <= 1'b0;
         r_data <= 8'h00;
      end else begin
         r_rs   <= i_lcd_rs;
         r_rw   <= i_lcd_rw;
         r_e    <= i_lcd_e;
         r_data <= i_lcd_data;
      end
   end

   // Track E history, hold the last E-high bus values and count high time
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_e_q      <= 1'b0;
         r_cap_rs   <= 1'b0;
         r_cap_rw   <= 1'b0;
         r_cap_data <= 8'h00;
         r_high_cnt <= 8'h00;
      end else begin
         r_e_q <= r_e;
         if (r_e) begin
            r_cap_rs   <= r_rs;
            r_cap_rw   <= r_rw;
            r_cap_data <= r_data;
            if (r_high_cnt != 8'hFF) begin
               r_high_cnt <= r_high_cnt + 8'd1;
            end
         end else begin
            r_high_cnt <= 8'h00;
         end
      end
   end

   // The counter still holds the full high time on the falling-edge cycle
   assign o_xfer      = r_e_q & ~r_e;
   assign o_rs        = r_cap_rs;
   assign o_rw        = r_cap_rw;
   assign o_data      = r_cap_data;
   assign o_too_short = (r_high_cnt < c_min_high);

endmodule
`default_nettype wire

// File: rtl/lcd_bus_monitor.sv
`default_nettype none
// ============================================================================
// Module      : lcd_bus_monitor
// Description : HD44780-style bus responder keeping a 32-character shadow of
//               the 16x2 display plus cursor and display-control state.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_bus_monitor
   import lcd_pkg::*;
#(
   parameter int         MIN_E_HIGH = 2,
   parameter logic [7:0] CLEAR_CHAR = LCD_CLEAR_CHAR,
   parameter int         LINE_LEN   = LCD_LINE_LEN
) (
   input  logic       clk,
   input  logic       rst,          // asynchronous, active-low
   input  logic       i_lcd_rs,
   input  logic       i_lcd_rw,
   input  logic       i_lcd_e,
   input  logic [7:0] i_lcd_data,
   input  logic [4:0] i_rd_index,
   output logic [7:0] o_rd_char,
   output logic [4:0] o_cursor_index,
   output logic       o_addr_valid,
   output logic       o_display_on,
   output logic       o_cursor_on,
   output logic       o_blink_on,
   output logic       o_busy,
   output logic       o_wr_strobe,
   output logic [7:0] o_err_cnt
);

   localparam logic [7:0] c_line_len = 8'(LINE_LEN);

   // Transfer from the sampler
   logic       w_xfer;
   logic       w_x_rs;
   logic       w_x_rw;
   logic [7:0] w_x_data;
   logic       w_too_short;

   // Decode
   logic       w_busy;
   logic       w_xfer_ok;
   logic       w_reject;
   logic       w_instr;
   logic       w_data_wr;
   logic       w_clr_cmd;
   logic [7:0] w_addr8;
   logic       w_in_l0;
   logic       w_in_l1;
   logic [4:0] w_ddr_idx;

   // State
   lcd_state_t r_state;
   lcd_state_t w_state_next;
   logic [4:0] r_clr_ptr;
   logic [4:0] r_cursor;
   logic       r_addr_valid;
   logic       r_id;
   logic       r_disp;
   logic       r_curs;
   logic       r_blink;
   logic       r_cgram;
   logic       r_wr_strobe;
   logic [7:0] r_err_cnt;
   logic [7:0] r_rd_char;
   logic [7:0] r_shadow [NUM_ENTRIES];

   lcd_bus_sampler #(
      .MIN_E_HIGH (MIN_E_HIGH)
   ) u_sampler (
      .clk         (clk),
      .rst         (rst),
      .i_lcd_rs    (i_lcd_rs),
      .i_lcd_rw    (i_lcd_rw),
      .i_lcd_e     (i_lcd_e),
      .i_lcd_data  (i_lcd_data),
      .o_xfer      (w_xfer),
      .o_rs        (w_x_rs),
      .o_rw        (w_x_rw),
      .o_data      (w_x_data),
      .o_too_short (w_too_short)
   );

   assign w_busy    = (r_state == ST_CLEAR);
   assign w_xfer_ok = w_xfer & ~w_too_short & ~w_x_rw & ~w_busy;
   assign w_reject  = w_xfer & ~w_xfer_ok;
   assign w_instr   = w_xfer_ok & ~w_x_rs;
   // Writes into CGRAM or outside the visible window are dropped, not errors
   assign w_data_wr = w_xfer_ok & w_x_rs & r_addr_valid & ~r_cgram;
   assign w_clr_cmd = w_instr & (w_x_data == OP_CLR);

   // DDRAM address to shadow index: line 0 window then line 1 window
   assign w_addr8   = {1'b0, w_x_data[6:0]};
   assign w_in_l0   = (w_addr8 >= LINE0_BASE) && (w_addr8 < (LINE0_BASE + c_line_len));
   assign w_in_l1   = (w_addr8 >= LINE1_BASE) && (w_addr8 < (LINE1_BASE + c_line_len));
   assign w_ddr_idx = w_in_l1 ? 5'(w_addr8 - LINE1_BASE + c_line_len)
                              : 5'(w_addr8 - LINE0_BASE);

   // FSM state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_CLEAR;
      end else begin
         r_state <= w_state_next;
      end
   end

   // FSM next state: clear sweeps all entries once, then returns to idle
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_clr_cmd) begin
               w_state_next = ST_CLEAR;
            end
         end
         ST_CLEAR: begin
            if (r_clr_ptr == 5'(NUM_ENTRIES - 1)) begin
               w_state_next = ST_IDLE;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   // Clear pointer advances one entry per busy cycle, parked at 0 otherwise
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_clr_ptr <= 5'd0;
      end else if (w_busy) begin
         r_clr_ptr <= r_clr_ptr + 5'd1;
      end else begin
         r_clr_ptr <= 5'd0;
      end
   end

   // Shadow register file; reset content comes from the clear sweep
   always_ff @(posedge clk) begin
      if (w_busy) begin
         r_shadow[r_clr_ptr] <= CLEAR_CHAR;
      end else if (w_data_wr) begin
         r_shadow[r_cursor] <= w_x_data;
      end
   end

   // Registered shadow readback, valid in every state
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rd_char <= 8'h00;
      end else begin
         r_rd_char <= r_shadow[i_rd_index];
      end
   end

   // Error counter and write strobe
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_err_cnt   <= 8'h00;
         r_wr_strobe <= 1'b0;
      end else begin
         r_wr_strobe <= w_data_wr;
         if (w_reject && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
         end
      end
   end

   // Cursor, entry mode and display control; instruction chosen by highest set bit
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cursor     <= 5'd0;
         r_addr_valid <= 1'b1;
         r_id         <= 1'b1;
         r_disp       <= 1'b0;
         r_curs       <= 1'b0;
         r_blink      <= 1'b0;
         r_cgram      <= 1'b0;
      end else if (w_data_wr) begin
         r_cursor <= step_cursor(r_cursor, r_id);
      end else if (w_instr) begin
         if (|(w_x_data & OP_DDRAM)) begin
            r_cgram <= 1'b0;
            if (w_in_l0 || w_in_l1) begin
               r_cursor     <= w_ddr_idx;
               r_addr_valid <= 1'b1;
            end else begin
               r_addr_valid <= 1'b0;
            end
         end else if (|(w_x_data & OP_CGRAM)) begin
            r_cgram <= 1'b1;
         end else if (|(w_x_data & OP_FUNC)) begin
            r_cgram <= r_cgram;  // function set is accepted without effect
         end else if (|(w_x_data & OP_SHIFT)) begin
            // bit3 = S/C (display shift ignored), bit2 = R/L
            if (!w_x_data[3]) begin
               r_cursor <= step_cursor(r_cursor, w_x_data[2]);
            end
         end else if (|(w_x_data & OP_DISP)) begin
            r_disp  <= w_x_data[2];
            r_curs  <= w_x_data[1];
            r_blink <= w_x_data[0];
         end else if (|(w_x_data & OP_ENTRY)) begin
            r_id <= w_x_data[1];
         end else if (|(w_x_data & OP_HOME)) begin
            r_cursor     <= 5'd0;
            r_addr_valid <= 1'b1;
         end else if (|(w_x_data & OP_CLR)) begin
            // position 0 is always inside the visible window
            r_cursor     <= 5'd0;
            r_addr_valid <= 1'b1;
            r_id         <= 1'b1;
            r_cgram      <= 1'b0;
         end
      end
   end

   assign o_rd_char      = r_rd_char;
   assign o_cursor_index = r_cursor;
   assign o_addr_valid   = r_addr_valid;
   assign o_display_on   = r_disp;
   assign o_cursor_on    = r_curs;
   assign o_blink_on     = r_blink;
   assign o_busy         = w_busy;
   assign o_wr_strobe    = r_wr_strobe;
   assign o_err_cnt      = r_err_cnt;

endmodule
`default_nettype wire
